// File: rtl/gf2_matrix_loader_if.sv
// Beat stream in, assembled matrix out, for the GF(2) matrix loader.
// slave is the loader side, master is the feeder/consumer side.
interface gf2_matrix_loader_if #(
    parameter int C = 4,
    parameter int R = C,
    parameter int W = 4
);
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [C*R-1:0] matrix;
    logic           matrix_valid;
    logic           matrix_ready;
    logic           frame_err;

    modport master (
        output in_data, in_valid, in_last, matrix_ready,
        input  in_ready, matrix, matrix_valid, frame_err
    );

    modport slave (
        input  in_data, in_valid, in_last, matrix_ready,
        output in_ready, matrix, matrix_valid, frame_err
    );
endinterface

// File: rtl/gf2_matrix_loader.sv
// Packs a frame of W-bit beats row-major into a C*R-bit GF(2) matrix; matrix_valid one cycle after the final beat.
// Latency: 1 cycle from final beat to matrix_valid; matrix and frame_err held while matrix_ready is low.
// Backpressure: in_ready low while presenting, unless GF2_MATRIX_LOADER_OVERLAP_EN lets the handshake cycle take beat 0.
module gf2_matrix_loader #(
    parameter int C = 4,
    parameter int R = C,
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst,
    gf2_matrix_loader_if.slave io
);
    localparam int MW   = C * R;
    localparam int N    = MW / W;
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(N - 1);

    generate
        if ((MW % W) != 0) begin : g_width_check
            $error("gf2_matrix_loader: C*R must be divisible by W");
        end
    endgenerate

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_eff;
    logic [MW-1:0]   mat_q;
    logic            err_q;

    logic            in_ready_c;
    logic            matrix_valid_c;
    logic            accept;
    logic            handshake;
    logic            at_end;
    logic            done;
    logic            err_d;

    // A beat taken during FULL always starts a fresh frame, so it is judged as beat 0.
    always_comb begin
        handshake = (state_q == FULL) & io.matrix_ready;
        cnt_eff   = (state_q == FULL) ? '0 : cnt_q;
        accept    = io.in_valid & in_ready_c;
        at_end    = (cnt_eff == LAST_IDX);
        done      = accept & (at_end | io.in_last);
        err_d     = io.in_last ^ at_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (done) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (handshake) begin
                    state_d = done ? FULL : FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready_c     = 1'b0;
        matrix_valid_c = 1'b0;
        case (state_q)
            FILL: begin
                in_ready_c = ~rst;
            end
            FULL: begin
                matrix_valid_c = 1'b1;
`ifdef GF2_MATRIX_LOADER_OVERLAP_EN
                in_ready_c     = io.matrix_ready & ~rst;
`else
                in_ready_c     = 1'b0;
`endif
            end
            default: begin
                in_ready_c     = 1'b0;
                matrix_valid_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mat_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (state_q == FILL) begin
            if (accept) begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CNTW'(k)) begin
                        mat_q[k*W +: W] <= io.in_data;
                    end
                end
                if (done) begin
                    cnt_q <= '0;
                    err_q <= err_d;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end else if (handshake) begin
            // Leaving FULL clears the buffer so a short next frame reads zero in its unwritten bits.
            mat_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            if (accept) begin
                mat_q[W-1:0] <= io.in_data;
                if (done) begin
                    err_q <= err_d;
                end else begin
                    cnt_q <= CNTW'(1);
                end
            end
        end
    end

    assign io.in_ready     = in_ready_c;
    assign io.matrix       = mat_q;
    assign io.matrix_valid = matrix_valid_c;
    assign io.frame_err    = err_q;
endmodule

// File: doc/gf2_matrix_loader.md
Name: gf2_matrix_loader

Overview:
- Upstream feeder for the constant-vector GF(2) multiply stage.
- Collects a streamed frame of W-bit beats into the flat C*R-bit matrix bus, row-major: row i, column j sits at bit i*C+j.
- Presents the assembled matrix with a valid/ready handshake and holds it stable while the combinational multiply stage and its consumer use it.
- Handles short frames by zero-padding and flags framing errors.

Parameters:
- C, 4, columns per row; must match the downstream multiply stage.
- R, C, rows per matrix; must match the downstream multiply stage.
- W, 4, input beat width in bits; C*R must be divisible by W (elaboration error otherwise).
- N, C*R/W, localparam: beats per full frame.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  W  beat payload.
- in_valid  input  1  beat valid.
- in_last  input  1  final beat of frame; qualified by in_valid.
- in_ready  output  1  loader accepts a beat this cycle.
- matrix  output  C*R  assembled matrix, row-major.
- matrix_valid  output  1  matrix complete and stable.
- matrix_ready  input  1  downstream consumes the matrix.
- frame_err  output  1  framing error for the presented matrix; valid only while matrix_valid=1.

Behaviour:
- States:
  - FILL: collecting beats.
  - FULL: presenting the matrix.
- Reset, synchronous, rst=1 at a clock edge:
  - state=FILL, beat count=0, matrix=0, matrix_valid=0, frame_err=0.
  - in_ready=0 in any cycle where rst=1.
  - Reset mid-frame or mid-FULL discards all content; no partial output.
- Beat acceptance: a beat is accepted when in_valid & in_ready.
  - Accepted beat k (k=0..N-1) writes matrix[k*W +: W]; count increments.
  - Beat 0 lands in the least significant bits.
- FILL:
  - in_ready=1, except during reset.
  - matrix_valid=0.
  - matrix bits not yet written read 0 (the buffer is zeroed on every entry to FILL).
- FILL -> FULL occurs on the accepted beat that satisfies either:
  - count==N-1, or
  - in_last=1.
  - matrix_valid=1 in the next cycle (one-cycle latency from the final beat).
- frame_err is registered on the same transition. It is 1 if either:
  - in_last=1 with count<N-1 (short frame; remaining bits stay 0), or
  - in_last=0 with count==N-1 (missing last).
  - Otherwise frame_err=0.
- FULL:
  - matrix and frame_err are held constant.
  - matrix_valid=1.
  - in_ready=0 (see optional feature).
- FULL -> FILL on matrix_valid & matrix_ready:
  - count=0, buffer zeroed, matrix_valid=0, frame_err=0 in the next cycle.
- Stalling: matrix_ready may stay low indefinitely; nothing changes while stalled.
- Signals with no effect:
  - in_valid=0: no state change, no matter what in_data or in_last carry.
  - matrix_ready while matrix_valid=0 is ignored.
- Throughput, no optional feature: N+1 cycles per frame when downstream is always ready (one bubble cycle after each handshake).

Optional Feature:
- Macro: GF2_MATRIX_LOADER_OVERLAP_EN.
- Defined:
  - In FULL, in_ready = matrix_ready.
  - A beat accepted in the handshake cycle becomes beat 0 of the next frame: written to bits [W-1:0], rest zeroed, count=1.
  - If that beat also completes a frame (N==1 or in_last=1), the state stays FULL with the new matrix and frame_err.
  - Back-to-back throughput: N cycles per frame.
- Undefined: in_ready=0 throughout FULL, as specified above.

Test Plan (C=4, R=4, W=4, N=4):
- Reset, then beats 0x1,0x2,0x3,0x4 with in_last on the 4th, matrix_ready=1 → matrix=0x4321, matrix_valid=1 for exactly one cycle, one cycle after beat 4; frame_err=0.
- Same frame with matrix_ready=0 for 10 cycles → matrix held at 0x4321, in_ready=0 throughout; released the cycle after matrix_ready rises.
- Beats 0xA,0xB with in_last on 0xB → matrix=0x00BA, frame_err=1.
- Four beats 0xF with in_last=0 → matrix=0xFFFF, frame_err=1; the next frame 0x1..0x4 with last → frame_err=0.
- Assert rst after 2 beats, then send a full frame 0x5,0x6,0x7,0x8 → matrix=0x8765, with no stale bits from the aborted frame.
- With GF2_MATRIX_LOADER_OVERLAP_EN, matrix_ready=1 and continuous valid beats → matrix_valid every 4 cycles and in_ready never 0 after reset; without the macro, one in_ready=0 cycle per frame.
